mem_port_arbiter: RTL

//   Shares one single-port memory between the CPU's instruction-fetch (IF) and data (DM) ports.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction-fetch and data ports
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t      state_q, state_d;
  logic        win_dm_q, win_dm_d;
  logic        lat_we_q, lat_we_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  starve_q, starve_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic        busy_q, busy_d;
  logic        dm_win;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      win_dm_q    <= 1'b0;
      lat_we_q    <= 1'b0;
      wait_cnt_q  <= '0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_dm_q    <= win_dm_d;
      lat_we_q    <= lat_we_d;
      wait_cnt_q  <= wait_cnt_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      busy_q      <= busy_d;
    end
  end

  // Outputs are registered, so each one is computed from the state being entered.
  always_comb begin
    state_d     = state_q;
    win_dm_d    = win_dm_q;
    lat_we_d    = lat_we_q;
    wait_cnt_d  = wait_cnt_q;
    starve_d    = starve_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    dm_win      = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          dm_win   = dm_req && !(if_req && (STARVE_LIM != 8'd0) && (starve_q == STARVE_LIM));
          win_dm_d = dm_win;
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          if (dm_win) begin
            lat_we_d    = dm_we;
            mem_we_d    = dm_we;
            mem_be_d    = dm_we ? dm_be : 4'hf;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            // Counts DM wins that made a waiting IF request lose; saturates at the limit.
            if (!if_req)                    starve_d = '0;
            else if (starve_q != STARVE_LIM) starve_d = starve_q + 8'd1;
          end else begin
            lat_we_d    = 1'b0;
            mem_be_d    = 4'hf;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
          end
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (wait_cnt_q == LAT_LAST) begin
          state_d = RESP;
          if (win_dm_q) begin
            dm_ack_d = 1'b1;
            if (!lat_we_q) dm_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
